stopwatch_count_core: RTL and testbench

Timekeeping datapath directly downstream of the stopwatch control FSM. Consumes its direction code, synchronous clear and load value, and divides the system clock into count ticks. Maintains a 0..MAX count with up-wrap and down-expire behaviour. Presents the count in binary (fed back to the controller as its `num` input) and as two BCD digits for the display stage.

---
 rtl/stopwatch_count_core_pkg.sv | 18 +
 rtl/stopwatch_count_core_if.sv | 21 ++
 rtl/stopwatch_count_core_bin2bcd_99.sv | 13 +
 rtl/stopwatch_count_core.sv | 85 ++++++++
 tb/tb_stopwatch_count_core.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/stopwatch_count_core_pkg.sv
// stopwatch_pkg: shared types and widths for the stopwatch count datapath.
//   mode_t      - direction code from the controller (01 is reserved, acts as stop)
//   cnt_state_t - internal counter FSM states
//   CNT_W       - width of the binary count and load value
package stopwatch_pkg;
    localparam int CNT_W = 7;
    typedef enum logic [1:0] {
        MODE_DOWN = 2'b00,
        MODE_UP   = 2'b10,
        MODE_STOP = 2'b11
    } mode_t;
    typedef enum logic [1:0] {
        HALT,
        RUN_UP,
        RUN_DOWN,
        EXPIRED
    } cnt_state_t;
endpackage

// File: rtl/stopwatch_count_core_if.sv
// stopwatch_count_core_if: controller <-> count core bundle.
//   controller -> core : clr, mode[1:0], load_en, load_val[6:0]
//   core -> controller : count[6:0], ones[3:0], tens[3:0], tick, wrap, expired
//   master = controller side, slave = count core side.
interface stopwatch_count_core_if;
    import stopwatch_pkg::*;
    logic             clr;
    logic [1:0]       mode;
    logic             load_en;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] count;
    logic [3:0]       ones;
    logic [3:0]       tens;
    logic             tick;
    logic             wrap;
    logic             expired;
    modport master (output clr, mode, load_en, load_val,
                    input  count, ones, tens, tick, wrap, expired);
    modport slave  (input  clr, mode, load_en, load_val,
                    output count, ones, tens, tick, wrap, expired);
endinterface

// File: rtl/stopwatch_count_core_bin2bcd_99.sv
// bin2bcd_99: combinational 7-bit binary to two BCD digits, valid for 0..99.
//   bin[6:0] in, tens[3:0] out, ones[3:0] out.
module bin2bcd_99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    logic [14:0] prod;
    // x*205/2048 equals floor(x/10) for every x up to 179, so no divider is needed.
    assign prod = 15'(bin) * 15'd205;
    assign tens = prod[14:11];
    assign ones = 4'(bin - {3'd0, tens} * 7'd10);
endmodule

// File: rtl/stopwatch_count_core.sv
// stopwatch_count_core: prescaled 0..MAX up/down counter with wrap, expiry and BCD outputs.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of stopwatch_count_core_if
//           in : clr (sync clear), mode (10 up, 00 down, 11/01 stop), load_en, load_val
//           out: count, ones, tens, tick, wrap, expired (all registered)
//   TICK_DIV - clk cycles per count tick (>= 2), MAX - largest count (<= 99)
module stopwatch_count_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX      = 99
) (
    input logic                  clk,
    input logic                  rst_n,
    stopwatch_count_core_if.slave bus
);
    localparam int               PW    = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    TERM  = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
    cnt_state_t       st_q, st_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       ones_q, ones_d, tens_q, tens_d;
    logic             tick_q, tick_d, wrap_q, wrap_d, exp_q, exp_d;
    logic             run, step;
    always_comb begin
        run     = st_q == RUN_UP || st_q == RUN_DOWN;
        step    = run && pre_q == TERM;
        pre_d   = run ? (step ? '0 : pre_q + PW'(1)) : pre_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        // The step direction comes from the current state; a mode change only affects the next state.
        if (step && st_q == RUN_UP) begin
            count_d = count_q == MAX_C ? '0 : count_q + CNT_W'(1);
            wrap_d  = count_q == MAX_C;
        end
        if (step && st_q == RUN_DOWN)
            count_d = count_q - CNT_W'(1);
        // Looking at the next count lets a down step that lands on 0 expire on the same edge.
        st_d = bus.mode == MODE_UP   ? RUN_UP :
               bus.mode == MODE_DOWN ? (count_d == '0 ? EXPIRED : RUN_DOWN) : HALT;
        if (bus.clr || bus.load_en) begin
            count_d = bus.clr ? '0 : (bus.load_val > MAX_C ? MAX_C : bus.load_val);
            pre_d   = '0;
            st_d    = HALT;
            wrap_d  = 1'b0;
        end
        // tick is a registered copy of the terminal-cycle condition of the next cycle.
        tick_d = (st_d == RUN_UP || st_d == RUN_DOWN) && pre_d == TERM;
        exp_d  = st_d == EXPIRED;
    end
    bin2bcd_99 u_bcd (
        .bin  (count_d),
        .tens (tens_d),
        .ones (ones_d)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= HALT;
            pre_q   <= '0;
            count_q <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            pre_q   <= pre_d;
            count_q <= count_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            exp_q   <= exp_d;
        end
    end
    assign bus.count   = count_q;
    assign bus.ones    = ones_q;
    assign bus.tens    = tens_q;
    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;
    assign bus.expired = exp_q;
endmodule

// File: tb/tb_stopwatch_count_core.sv
// tb_stopwatch_count_core: directed self-checking bench for stopwatch_count_core (TICK_DIV=4, MAX=99).
module tb_stopwatch_count_core;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    stopwatch_count_core_if bus ();
    stopwatch_count_core #(.TICK_DIV(4), .MAX(99)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic tk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    initial begin
        rst_n = 1'b0; bus.clr = 1'b0; bus.mode = 2'b11; bus.load_en = 1'b0; bus.load_val = '0;
        tk(2);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_ones", 32'(bus.ones), 0);
        chk("rst_tens", 32'(bus.tens), 0);
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_wrap", 32'(bus.wrap), 0);
        chk("rst_expired", 32'(bus.expired), 0);
        rst_n = 1'b1;
        tk(3);
        chk("halt_after_rst", 32'(bus.count), 0);
        // clamped load
        bus.load_en = 1'b1; bus.load_val = 7'd103;
        tk(1);
        chk("clamp_count", 32'(bus.count), 99);
        chk("clamp_tens", 32'(bus.tens), 9);
        chk("clamp_ones", 32'(bus.ones), 9);
        bus.load_en = 1'b0;
        tk(3);
        chk("stop_hold", 32'(bus.count), 99);
        // up count and wrap
        bus.load_en = 1'b1; bus.load_val = 7'd98;
        tk(1);
        chk("load98_count", 32'(bus.count), 98);
        chk("load98_ones", 32'(bus.ones), 8);
        bus.load_en = 1'b0; bus.mode = 2'b10;
        tk(3);
        chk("up_pre_count", 32'(bus.count), 98);
        chk("up_pre_tick", 32'(bus.tick), 0);
        tk(1);
        chk("up_tick1", 32'(bus.tick), 1);
        tk(1);
        chk("up_count99", 32'(bus.count), 99);
        chk("up_tick_drop", 32'(bus.tick), 0);
        chk("up_tens99", 32'(bus.tens), 9);
        chk("up_ones99", 32'(bus.ones), 9);
        tk(3);
        chk("up_tick2", 32'(bus.tick), 1);
        chk("up_nowrap", 32'(bus.wrap), 0);
        tk(1);
        chk("wrap_count", 32'(bus.count), 0);
        chk("wrap_pulse", 32'(bus.wrap), 1);
        chk("wrap_tens", 32'(bus.tens), 0);
        chk("wrap_ones", 32'(bus.ones), 0);
        tk(1);
        chk("wrap_single", 32'(bus.wrap), 0);
        chk("wrap_after", 32'(bus.count), 0);
        // load coincident with a tick
        tk(2);
        chk("pre_load_tick", 32'(bus.tick), 1);
        bus.load_en = 1'b1; bus.load_val = 7'd50;
        tk(1);
        chk("load_on_tick", 32'(bus.count), 50);
        chk("load_tick_off", 32'(bus.tick), 0);
        bus.load_en = 1'b0;
        tk(4);
        chk("resume_tick", 32'(bus.tick), 1);
        chk("resume_count", 32'(bus.count), 50);
        tk(1);
        chk("count51", 32'(bus.count), 51);
        // pause and resume
        tk(2);
        bus.mode = 2'b11;
        tk(11);
        chk("pause_count", 32'(bus.count), 51);
        chk("pause_tick", 32'(bus.tick), 0);
        bus.mode = 2'b10;
        tk(1);
        chk("resume1_tick", 32'(bus.tick), 1);
        chk("resume1_count", 32'(bus.count), 51);
        tk(1);
        chk("resume2_count", 32'(bus.count), 52);
        // down to expiry
        bus.mode = 2'b11; bus.load_en = 1'b1; bus.load_val = 7'd2;
        tk(1);
        chk("load2", 32'(bus.count), 2);
        bus.load_en = 1'b0; bus.mode = 2'b00;
        tk(4);
        chk("down_tick", 32'(bus.tick), 1);
        chk("down_pre", 32'(bus.count), 2);
        tk(1);
        chk("down_count1", 32'(bus.count), 1);
        chk("down_not_exp", 32'(bus.expired), 0);
        tk(4);
        chk("down_count0", 32'(bus.count), 0);
        chk("expired_rise", 32'(bus.expired), 1);
        chk("down_ones0", 32'(bus.ones), 0);
        for (int i = 0; i < 20; i++) begin
            tk(1);
            chk("expired_notick", 32'(bus.tick), 0);
        end
        chk("expired_hold", 32'(bus.count), 0);
        chk("expired_level", 32'(bus.expired), 1);
        // leave expiry by switching to up
        bus.mode = 2'b10;
        tk(1);
        chk("exp_exit", 32'(bus.expired), 0);
        chk("exp_exit_count", 32'(bus.count), 0);
        // clr beats load
        bus.clr = 1'b1; bus.load_en = 1'b1; bus.load_val = 7'd50;
        tk(1);
        chk("clr_over_load", 32'(bus.count), 0);
        bus.clr = 1'b0;
        // asynchronous reset mid-run
        bus.load_val = 7'd37;
        tk(1);
        bus.load_en = 1'b0;
        tk(2);
        chk("pre_reset_count", 32'(bus.count), 37);
        chk("pre_reset_tens", 32'(bus.tens), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", 32'(bus.count), 0);
        chk("async_tens", 32'(bus.tens), 0);
        chk("async_ones", 32'(bus.ones), 0);
        chk("async_tick", 32'(bus.tick), 0);
        bus.mode = 2'b11;
        tk(1);
        rst_n = 1'b1;
        tk(3);
        chk("post_reset_count", 32'(bus.count), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
